// File: rtl/cu_regfile_pkg.sv
// Shared CU parameter package.
// Holds the default register-file geometry and the data-move FSM state
// encoding. The crossbar imports this package too, so both sides agree on
// data and address widths.
package cu_regfile_pkg;

  localparam int CU_DATA_WIDTH    = 16;
  localparam int CU_ADDRESS_WIDTH = 4;

  // Data-move port FSM.
  //   IDLE: waiting for a request
  //   WAIT: write accepted, crossbar still owns the write port
  //   ACK : single-cycle completion pulse
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dm_state_e;

endpackage

// File: rtl/cu_regfile_rf_dm_arb.sv
// rf_dm_arb: data-move port FSM for the CU register file.
// Arbitrates the data-move port against the crossbar for the single write
// port. Emits same-cycle strobes that act at the coming edge, plus a
// registered ack.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   req, wr     : data-move request (held until ack) and direction
//   xb_w_en     : crossbar write enable (wins the write port)
//   dm_wr_sel   : write reg[dm_add] <= dm data at this edge
//   dm_rd_cap   : capture reg[dm_add] into the read-data register at this edge
//   ack         : one-cycle completion pulse (registered)
module rf_dm_arb
  import cu_regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic wr,
  input  logic xb_w_en,
  output logic dm_wr_sel,
  output logic dm_rd_cap,
  output logic ack
);

  dm_state_e state, state_nxt;

  always_comb begin
    state_nxt = state;
    dm_wr_sel = 1'b0;
    dm_rd_cap = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (!wr) begin
            dm_rd_cap = 1'b1;
            state_nxt = ACK;
          end else if (!xb_w_en) begin
            dm_wr_sel = 1'b1;
            state_nxt = ACK;
          end else begin
            // Crossbar holds the write port; retry once it lets go.
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // Address/data come straight from the requester at the executing
        // edge; it keeps them stable until ack.
        if (!xb_w_en) begin
          dm_wr_sel = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        // req is ignored here, so back-to-back transfers are 2 cycles apart.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      ack   <= (state_nxt == ACK);
    end
  end

endmodule

// File: rtl/cu_regfile.sv
// cu_regfile: CU register file with two combinational read ports (X/Y) for
// the crossbar, one crossbar write port, and a handshaked data-move port
// that shares the single write port with the crossbar.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   xb_rf_w_En/ps_rf_wadd/xb_rf_dt : crossbar write
//   ps_rf_raddx/ps_rf_raddy   : X/Y read addresses
//   rf_xb_dtx/rf_xb_dty       : X/Y read data (combinational, no bypass)
//   ps_rf_dm_req/_wr/_add, dm_rf_dt : data-move request, direction, address, data
//   rf_dm_dt                  : data-move read data (registered, held)
//   rf_dm_ack                 : data-move completion pulse
module cu_regfile
  import cu_regfile_pkg::*;
#(
  parameter int DATA_WIDTH    = CU_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = CU_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     xb_rf_w_En,
  input  logic [ADDRESS_WIDTH-1:0] ps_rf_wadd,
  input  logic [DATA_WIDTH-1:0]    xb_rf_dt,
  input  logic [ADDRESS_WIDTH-1:0] ps_rf_raddx,
  input  logic [ADDRESS_WIDTH-1:0] ps_rf_raddy,
  output logic [DATA_WIDTH-1:0]    rf_xb_dtx,
  output logic [DATA_WIDTH-1:0]    rf_xb_dty,
  input  logic                     ps_rf_dm_req,
  input  logic                     ps_rf_dm_wr,
  input  logic [ADDRESS_WIDTH-1:0] ps_rf_dm_add,
  input  logic [DATA_WIDTH-1:0]    dm_rf_dt,
  output logic [DATA_WIDTH-1:0]    rf_dm_dt,
  output logic                     rf_dm_ack
);

  localparam int NUM_REGS = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  dm_wr_sel;
  logic                  dm_rd_cap;

  rf_dm_arb u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (ps_rf_dm_req),
    .wr        (ps_rf_dm_wr),
    .xb_w_en   (xb_rf_w_En),
    .dm_wr_sel (dm_wr_sel),
    .dm_rd_cap (dm_rd_cap),
    .ack       (rf_dm_ack)
  );

  // No write-to-read bypass: the crossbar does its own forwarding.
  assign rf_xb_dtx = regs[ps_rf_raddx];
  assign rf_xb_dty = regs[ps_rf_raddy];

  // Single write port. The arbiter only raises dm_wr_sel when the crossbar
  // is idle; the crossbar is still listed first so it can never lose.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (xb_rf_w_En) begin
      regs[ps_rf_wadd] <= xb_rf_dt;
    end else if (dm_wr_sel) begin
      regs[ps_rf_dm_add] <= dm_rf_dt;
    end
  end

  // Captures the pre-edge value, so a same-edge crossbar write to the same
  // address is not seen. Held until the next read completes.
  always_ff @(posedge clk) begin
    if (reset)          rf_dm_dt <= '0;
    else if (dm_rd_cap) rf_dm_dt <= regs[ps_rf_dm_add];
  end

endmodule

// File: tb/tb_cu_regfile.sv
module tb_cu_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        xb_rf_w_En;
  logic [3:0]  ps_rf_wadd;
  logic [15:0] xb_rf_dt;
  logic [3:0]  ps_rf_raddx, ps_rf_raddy;
  logic [15:0] rf_xb_dtx, rf_xb_dty;
  logic        ps_rf_dm_req, ps_rf_dm_wr;
  logic [3:0]  ps_rf_dm_add;
  logic [15:0] dm_rf_dt, rf_dm_dt;
  logic        rf_dm_ack;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mreg [16];      // reference register contents
  logic [15:0] sb [$];         // expected data-move read results
  logic [15:0] last_rd;        // last data-move read value

  typedef struct {
    logic        we;
    logic [3:0]  wadd;
    logic [15:0] dt;
    logic [3:0]  rx;
    logic [3:0]  ry;
    logic [15:0] ex;
    logic [15:0] ey;
  } vec_t;
  vec_t vt [8];

  cu_regfile #(.DATA_WIDTH(16), .ADDRESS_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .xb_rf_w_En   (xb_rf_w_En),
    .ps_rf_wadd   (ps_rf_wadd),
    .xb_rf_dt     (xb_rf_dt),
    .ps_rf_raddx  (ps_rf_raddx),
    .ps_rf_raddy  (ps_rf_raddy),
    .rf_xb_dtx    (rf_xb_dtx),
    .rf_xb_dty    (rf_xb_dty),
    .ps_rf_dm_req (ps_rf_dm_req),
    .ps_rf_dm_wr  (ps_rf_dm_wr),
    .ps_rf_dm_add (ps_rf_dm_add),
    .dm_rf_dt     (dm_rf_dt),
    .rf_dm_dt     (rf_dm_dt),
    .rf_dm_ack    (rf_dm_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare all 16 registers through X (ascending) and Y (descending).
  task automatic readback(input string nm);
    for (int i = 0; i < 16; i++) begin
      ps_rf_raddx = 4'(i);
      ps_rf_raddy = 4'(15 - i);
      #1;
      chk($sformatf("%s x[%0d]", nm, i), {16'h0, rf_xb_dtx}, {16'h0, mreg[i]});
      chk($sformatf("%s y[%0d]", nm, 15 - i), {16'h0, rf_xb_dty}, {16'h0, mreg[15-i]});
    end
  endtask

  // One data-move transfer. The crossbar writes xd+n to xa+n on the first
  // xbn edges. exp_lat is the number of edges from request to visible ack.
  task automatic dm_op(input logic w, input logic [3:0] a, input logic [15:0] d,
                       input int xbn, input logic [3:0] xa, input logic [15:0] xd,
                       input int exp_lat, input string nm);
    int n;
    bit got;
    logic [15:0] e;
    if (!w) sb.push_back(mreg[a]);
    ps_rf_dm_req = 1'b1;
    ps_rf_dm_wr  = w;
    ps_rf_dm_add = a;
    dm_rf_dt     = d;
    n   = 0;
    got = 0;
    while (!got && n < 20) begin
      xb_rf_w_En = (n < xbn);
      ps_rf_wadd = xa + 4'(n);
      xb_rf_dt   = xd + 16'(n);
      if (n < xbn) mreg[xa + 4'(n)] = xd + 16'(n);
      if (w && n == xbn) mreg[a] = d;
      step();
      n++;
      if (rf_dm_ack) got = 1;
    end
    chk({nm, " latency"}, 32'(n), 32'(exp_lat));
    if (got) begin
      if (!w) begin
        if (sb.size() == 0) begin
          chk({nm, " sb nonempty"}, 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk({nm, " rd data"}, {16'h0, rf_dm_dt}, {16'h0, e});
          last_rd = e;
        end
      end else begin
        chk({nm, " rd data held"}, {16'h0, rf_dm_dt}, {16'h0, last_rd});
      end
    end
    ps_rf_dm_req = 1'b0;
    xb_rf_w_En   = 1'b0;
    step();
    chk({nm, " ack one cycle"}, {31'h0, rf_dm_ack}, 32'h0);
  endtask

  initial begin
    // Table: expected X/Y are the pre-edge values of the vector's own cycle.
    vt[0] = '{1'b1, 4'd3,  16'hBEEF, 4'd3,  4'd0,  16'h0000, 16'h0000};
    vt[1] = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd3,  16'hBEEF, 16'hBEEF};
    vt[2] = '{1'b1, 4'd0,  16'h5A5A, 4'd3,  4'd0,  16'hBEEF, 16'h0000};
    vt[3] = '{1'b1, 4'd15, 16'hFFFF, 4'd0,  4'd15, 16'h5A5A, 16'h0000};
    vt[4] = '{1'b1, 4'd3,  16'h0102, 4'd15, 4'd3,  16'hFFFF, 16'hBEEF};
    vt[5] = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd15, 16'h0102, 16'hFFFF};
    vt[6] = '{1'b1, 4'd2,  16'h0011, 4'd2,  4'd0,  16'h0000, 16'h5A5A};
    vt[7] = '{1'b0, 4'd0,  16'h0000, 4'd2,  4'd3,  16'h0011, 16'h0102};

    for (int i = 0; i < 16; i++) mreg[i] = 16'h0;
    last_rd      = 16'h0;
    reset        = 1'b1;
    xb_rf_w_En   = 1'b0;
    ps_rf_wadd   = 4'd0;
    xb_rf_dt     = 16'h0;
    ps_rf_raddx  = 4'd0;
    ps_rf_raddy  = 4'd0;
    ps_rf_dm_req = 1'b0;
    ps_rf_dm_wr  = 1'b0;
    ps_rf_dm_add = 4'd0;
    dm_rf_dt     = 16'h0;
    step();
    step();
    reset = 1'b0;

    chk("reset ack", {31'h0, rf_dm_ack}, 32'h0);
    chk("reset dm_dt", {16'h0, rf_dm_dt}, 32'h0);
    readback("reset");

    // Crossbar write/read table.
    for (int i = 0; i < 8; i++) begin
      xb_rf_w_En  = vt[i].we;
      ps_rf_wadd  = vt[i].wadd;
      xb_rf_dt    = vt[i].dt;
      ps_rf_raddx = vt[i].rx;
      ps_rf_raddy = vt[i].ry;
      #1;
      chk($sformatf("vec%0d x", i), {16'h0, rf_xb_dtx}, {16'h0, vt[i].ex});
      chk($sformatf("vec%0d y", i), {16'h0, rf_xb_dty}, {16'h0, vt[i].ey});
      if (vt[i].we) mreg[vt[i].wadd] = vt[i].dt;
      step();
    end
    xb_rf_w_En = 1'b0;

    // Uncontended write then read back through the data-move port.
    dm_op(1'b1, 4'd5, 16'h1234, 0, 4'd0, 16'h0, 1, "dm wr5");
    dm_op(1'b0, 4'd5, 16'h0,    0, 4'd0, 16'h0, 1, "dm rd5");

    // Contended write: crossbar busy 3 cycles on regs 8..10.
    dm_op(1'b1, 4'd7, 16'hAAAA, 3, 4'd8, 16'h1000, 4, "dm wr7 contend");
    readback("after contend");

    // Read racing a same-edge crossbar write to the same register.
    dm_op(1'b0, 4'd2, 16'h0, 1, 4'd2, 16'h0022, 1, "dm rd2 race");
    ps_rf_raddx = 4'd2;
    #1;
    chk("reg2 after race", {16'h0, rf_xb_dtx}, 32'h0022);

    // Reset while the data-move write is parked in WAIT.
    ps_rf_dm_req = 1'b1;
    ps_rf_dm_wr  = 1'b1;
    ps_rf_dm_add = 4'd6;
    dm_rf_dt     = 16'h7777;
    xb_rf_w_En   = 1'b1;
    ps_rf_wadd   = 4'd1;
    xb_rf_dt     = 16'h4444;
    step();
    chk("wait no ack", {31'h0, rf_dm_ack}, 32'h0);
    reset = 1'b1;
    step();
    reset        = 1'b0;
    ps_rf_dm_req = 1'b0;
    xb_rf_w_En   = 1'b0;
    for (int i = 0; i < 16; i++) mreg[i] = 16'h0;
    last_rd = 16'h0;
    chk("rst-in-wait dm_dt", {16'h0, rf_dm_dt}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst-in-wait no ack %0d", i), {31'h0, rf_dm_ack}, 32'h0);
      step();
    end
    readback("rst-in-wait");

    // Port still usable after the abandoned transfer.
    dm_op(1'b0, 4'd6, 16'h0, 0, 4'd0, 16'h0, 1, "dm rd6 post-reset");

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cu_regfile.md
CU_REGFILE -- requirements
Module: cu_regfile

Interface
REQ-001 The module SHALL take parameter DATA_WIDTH, default 16, giving the register and data width.
REQ-002 The module SHALL take parameter ADDRESS_WIDTH, default 4, giving 2^ADDRESS_WIDTH registers.
REQ-003 The module SHALL have exactly one clock and one reset: the reset is synchronous and active-high.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 xb_rf_w_En  input  1  crossbar write enable.
REQ-007 ps_rf_wadd  input  ADDRESS_WIDTH  crossbar write address.
REQ-008 xb_rf_dt  input  DATA_WIDTH  crossbar write data.
REQ-009 ps_rf_raddx  input  ADDRESS_WIDTH  X read address.
REQ-010 ps_rf_raddy  input  ADDRESS_WIDTH  Y read address.
REQ-011 rf_xb_dtx  output  DATA_WIDTH  X read data.
REQ-012 rf_xb_dty  output  DATA_WIDTH  Y read data.
REQ-013 ps_rf_dm_req  input  1  data-move port request, held until ack.
REQ-014 ps_rf_dm_wr  input  1  1 = write, 0 = read, valid with req.
REQ-015 ps_rf_dm_add  input  ADDRESS_WIDTH  data-move address, valid with req.
REQ-016 dm_rf_dt  input  DATA_WIDTH  data-move write data, valid with req.
REQ-017 rf_dm_dt  output  DATA_WIDTH  data-move read data, registered.
REQ-018 rf_dm_ack  output  1  one-cycle completion pulse.

Function
REQ-019 X/Y reads SHALL be combinational from current register contents, with no internal bypass, because forwarding is done by the crossbar.
REQ-020 When xb_rf_w_En=1, reg[ps_rf_wadd] SHALL take the value xb_rf_dt at the rising edge.
REQ-021 The data-move port SHALL use FSM states IDLE, WAIT, ACK.
REQ-022 IDLE, req=1, wr=0: at the edge, capture reg[add] (pre-edge value) into rf_dm_dt, then go to ACK.
REQ-023 IDLE, req=1, wr=1, xb_rf_w_En=0: at the edge, write reg[add]<=dm_rf_dt, then go to ACK.
REQ-024 IDLE, req=1, wr=1, xb_rf_w_En=1: perform no write and go to WAIT, because the crossbar owns the single write port.
REQ-025 WAIT: while xb_rf_w_En=1, stay in WAIT; on the first cycle with xb_rf_w_En=0, perform the write and go to ACK.
REQ-026 In WAIT, the address and data SHALL be sampled at the executing edge, since the requester holds them stable.
REQ-027 ACK: rf_dm_ack=1 for exactly this cycle, then go to IDLE; req is ignored in ACK, so minimum spacing is 2 cycles per transfer.
REQ-028 rf_dm_ack SHALL be 0 in every state other than ACK.
REQ-029 Latency: a read or an uncontended write acks 1 cycle after acceptance; a contended write acks 1 cycle after the crossbar releases the write port.
REQ-030 A data-move read to the same address as a same-cycle crossbar write SHALL return the old value.
REQ-031 rf_dm_dt SHALL hold its last read value until the next read completes.
REQ-032 Writes to register 0 SHALL be ordinary; no register is hardwired.
REQ-033 rf_dm_dt SHALL NOT update on a data-move write.

Reset
REQ-034 While reset=1 at an edge, all registers SHALL become 0, FSM=IDLE, rf_dm_ack=0, rf_dm_dt=0.
REQ-035 Reset SHALL dominate a same-edge crossbar write and any data-move transfer.
REQ-036 Reset asserted in WAIT or ACK SHALL abandon the transfer with no write and no ack.

Structure
REQ-037 DATA_WIDTH/ADDRESS_WIDTH defaults and the FSM state encodings SHALL live in the shared CU parameter package, also used by the crossbar.
REQ-038 The data-move FSM SHALL be one sub-module, rf_dm_arb, producing the write select, the capture enable and ack.
REQ-039 The register array and read muxes SHALL stay in cu_regfile.

Verification
REQ-040 After reset, read all 16 addresses on X and Y -> every value 0x0000.
REQ-041 xb_rf_w_En=1, wadd=3, dt=0xBEEF, then raddx=3 next cycle -> rf_xb_dtx=0xBEEF; in the write cycle itself, the pre-write value.
REQ-042 DM write add=5, dt=0x1234 with xb idle -> ack exactly 1 cycle later; a following DM read of add 5 -> rf_dm_dt=0x1234 with ack pulse.
REQ-043 DM write add=7, dt=0xAAAA while xb writes for 3 consecutive cycles -> FSM in WAIT for 3 cycles, write on the 4th edge, ack on the next cycle; reg7=0xAAAA, xb writes intact.
REQ-044 DM read add=2 (value 0x0011) in the same cycle xb writes 0x0022 to add 2 -> rf_dm_dt=0x0011, reg2=0x0022.
REQ-045 Assert reset while in WAIT -> no write to the target, no ack, all registers 0, FSM IDLE.
